// File: rtl/adrv9001_tx_pkg.sv
// Shared definitions for the ADRV9001 transmit sample path.
//   ST_IDLE / ST_PREFILL / ST_RUN : FSM encoding, also exported on the state port
//   UNDERFLOW_CNT_W               : width of the saturating zero-fill counter
package adrv9001_tx_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PREFILL = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    localparam int UNDERFLOW_CNT_W = 16;

endpackage

// File: rtl/adrv9001_tx_fifo_ram.sv
// Simple dual-port sample store: synchronous write, asynchronous read, so it
// maps onto distributed RAM and the head word is available in the same cycle.
//   clk          : write clock
//   we/waddr/wdata : write port
//   raddr/rdata  : combinational read port
module adrv9001_tx_fifo_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adrv9001_tx_sample_fifo.sv
// Elastic IQ sample buffer feeding the ADRV9001 transmit channel.
// Holds off output until a prefill level is reached, then presents one word per
// m_axis_tready pulse. Since the channel samples on every tready, an empty FIFO
// inserts a zero sample and counts it instead of stalling.
//   clk, rst              : sample clock, async active-high reset
//   enable                : start (rising) / stop and flush (low)
//   prefill_level         : words needed before RUN (clamped to 1..DEPTH)
//   s_axis_*              : sample input
//   m_axis_*              : sample output to the transmit channel
//   level                 : current word count
//   underflow_cnt/underflow : zero-fill statistics since last start
//   state                 : FSM state (IDLE/PREFILL/RUN)
module adrv9001_tx_sample_fifo
    import adrv9001_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [ADDR_WIDTH:0]        prefill_level,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [ADDR_WIDTH:0]        level,
    output logic [UNDERFLOW_CNT_W-1:0] underflow_cnt,
    output logic                       underflow,
    output logic [1:0]                 state
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   target;
    logic [DATA_WIDTH-1:0] head;
    logic                  push, pop, zero_fill;

    // Effective prefill target: 0 would never start cleanly, >DEPTH would never start.
    always_comb begin
        target = prefill_level;
        if (prefill_level > DEPTH_CNT) target = DEPTH_CNT;
        if (prefill_level == '0)       target = CNT_ONE;
    end

    assign level         = count;
    assign s_axis_tready = (state != ST_IDLE) && (count < DEPTH_CNT);

    // Writes on a disabling edge are dropped along with the flush.
    assign push = enable && s_axis_tvalid && s_axis_tready;

    // Head load: once on the PREFILL->RUN edge, then on every non-empty pulse.
    assign pop = enable && (((state == ST_PREFILL) && (count >= target)) ||
                            ((state == ST_RUN) && m_axis_tready && (count != '0)));

    // Pop at empty sees empty even if a push lands on the same edge.
    assign zero_fill = enable && (state == ST_RUN) && m_axis_tready && (count == '0);

    adrv9001_tx_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            underflow_cnt <= '0;
            underflow     <= 1'b0;
        end else if (!enable) begin
            // Stop and flush; statistics stay readable until the next start.
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state         <= ST_PREFILL;
                    underflow_cnt <= '0;
                    underflow     <= 1'b0;
                end
                ST_PREFILL: begin
                    if (count >= target) begin
                        state         <= ST_RUN;
                        m_axis_tvalid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (zero_fill) begin
                        m_axis_tdata <= '0;
                        underflow    <= 1'b1;
                        if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_ONE;
                m_axis_tdata <= head;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_adrv9001_tx_sample_fifo.sv
// Directed bench for adrv9001_tx_sample_fifo: prefill, underflow, full,
// flush, edge cases and asynchronous reset, with hand-computed expectations.
module tb_adrv9001_tx_sample_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [6:0]  prefill_level;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [6:0]  level;
    logic [15:0] underflow_cnt;
    logic        underflow;
    logic [1:0]  state;

    int n_chk  = 0;
    int n_fail = 0;
    int acc;

    always #5 clk = ~clk;

    adrv9001_tx_sample_fifo #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .prefill_level (prefill_level),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .level         (level),
        .underflow_cnt (underflow_cnt),
        .underflow     (underflow),
        .state         (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One downstream tready pulse followed by an idle cycle.
    task automatic pulse();
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        tick();
    endtask

    task automatic write1(input logic [31:0] d);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; prefill_level = 7'd8;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        tick();
        check("rst_state",  32'(state), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata",  m_axis_tdata, 32'd0);
        check("rst_sready", 32'(s_axis_tready), 32'd0);
        check("rst_level",  32'(level), 32'd0);
        rst = 1'b0;
        tick();

        // Prefill to 8, then stream out in order
        enable = 1'b1;
        tick();
        check("pf_state", 32'(state), 32'd1);
        check("pf_sready", 32'(s_axis_tready), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            write1({i[15:0], i[15:0]});
            check("pf_level", 32'(level), 32'(i));
        end
        check("pf_still_prefill", 32'(state), 32'd1);
        check("pf_tvalid_low", 32'(m_axis_tvalid), 32'd0);
        tick();
        check("run_state", 32'(state), 32'd2);
        check("run_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("run_first", m_axis_tdata, 32'h0001_0001);
        check("run_level", 32'(level), 32'd7);
        for (int i = 2; i <= 8; i++) begin
            pulse();
            check("run_seq", m_axis_tdata, {i[15:0], i[15:0]});
        end
        check("run_empty", 32'(level), 32'd0);
        check("run_ucnt0", 32'(underflow_cnt), 32'd0);
        check("run_uf0", 32'(underflow), 32'd0);

        // Underflow: three zero-fill pulses
        for (int i = 0; i < 3; i++) begin
            pulse();
            check("uf_zero", m_axis_tdata, 32'd0);
        end
        check("uf_cnt", 32'(underflow_cnt), 32'd3);
        check("uf_sticky", 32'(underflow), 32'd1);
        check("uf_state", 32'(state), 32'd2);
        write1(32'hABCD_1234);
        check("uf_level1", 32'(level), 32'd1);
        pulse();
        check("uf_resume", m_axis_tdata, 32'hABCD_1234);
        check("uf_cnt_hold", 32'(underflow_cnt), 32'd3);

        // Disable/flush with 20 words buffered
        for (int i = 0; i < 20; i++) write1(32'hC000_0000 + 32'(i));
        check("fl_level20", 32'(level), 32'd20);
        enable = 1'b0;
        tick();
        check("fl_state", 32'(state), 32'd0);
        check("fl_level", 32'(level), 32'd0);
        check("fl_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("fl_tdata", m_axis_tdata, 32'd0);
        check("fl_sready", 32'(s_axis_tready), 32'd0);
        prefill_level = 7'd1;
        enable = 1'b1;
        tick();
        check("re_state", 32'(state), 32'd1);
        check("re_ucnt", 32'(underflow_cnt), 32'd0);
        check("re_uf", 32'(underflow), 32'd0);
        write1(32'h0000_0055);
        tick();
        check("re_state_run", 32'(state), 32'd2);
        check("re_fresh", m_axis_tdata, 32'h0000_0055);

        // Full: prefill 64, offer 70 words with no reads
        enable = 1'b0;
        tick();
        prefill_level = 7'd64;
        enable = 1'b1;
        tick();
        acc = 0;
        for (int n = 0; n < 70; n++) begin
            s_axis_tdata  = 32'h100 + 32'(n);
            s_axis_tvalid = 1'b1;
            if (!s_axis_tready) break;
            acc++;
            tick();
        end
        check("full_accepted", 32'(acc), 32'd64);
        check("full_level", 32'(level), 32'd64);
        check("full_sready", 32'(s_axis_tready), 32'd0);
        tick();
        s_axis_tvalid = 1'b0;
        check("full_run", 32'(state), 32'd2);
        check("full_head", m_axis_tdata, 32'h0000_0100);
        check("full_level63", 32'(level), 32'd63);
        write1(32'hDEAD_0000);
        check("full_again", 32'(level), 32'd64);
        s_axis_tdata = 32'hDEAD_0001; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        check("full_sready_pop", 32'(s_axis_tready), 32'd0);
        tick();
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        check("full_pop_only", 32'(level), 32'd63);
        check("full_second", m_axis_tdata, 32'h0000_0101);

        // prefill_level=0 behaves as 1; push+pop at empty
        enable = 1'b0;
        tick();
        prefill_level = 7'd0;
        enable = 1'b1;
        tick();
        write1(32'h0000_0077);
        check("p0_prefill", 32'(state), 32'd1);
        tick();
        check("p0_run", 32'(state), 32'd2);
        check("p0_data", m_axis_tdata, 32'h0000_0077);
        check("p0_level0", 32'(level), 32'd0);
        s_axis_tdata = 32'h0000_0088; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        tick();
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        check("pp_zero", m_axis_tdata, 32'd0);
        check("pp_ucnt", 32'(underflow_cnt), 32'd1);
        check("pp_level", 32'(level), 32'd1);
        tick();
        pulse();
        check("pp_landed", m_axis_tdata, 32'h0000_0088);

        // Asynchronous reset between edges
        write1(32'h0000_0099);
        write1(32'h0000_009A);
        #2;
        rst = 1'b1;
        #1;
        check("ar_state", 32'(state), 32'd0);
        check("ar_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("ar_tdata", m_axis_tdata, 32'd0);
        check("ar_level", 32'(level), 32'd0);
        check("ar_sready", 32'(s_axis_tready), 32'd0);
        check("ar_ucnt", 32'(underflow_cnt), 32'd0);
        check("ar_uf", 32'(underflow), 32'd0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("ar_idle", 32'(state), 32'd0);
        enable = 1'b1;
        tick();
        check("ar_restart", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
